// File: rtl/sad_min_select_if.sv
// rtl/sad_min_select_if.sv - candidate SAD stream in, best motion vector result out
interface sad_min_select_if #(
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 5
);
  logic                        sad_start;
  logic                        sad_valid;
  logic [SAD_WIDTH-1:0]        sad_in;
  logic                        busy;
  logic                        result_valid;
  logic [SAD_WIDTH-1:0]        best_sad;
  logic signed [MV_WIDTH-1:0]  best_mv_x;
  logic signed [MV_WIDTH-1:0]  best_mv_y;

  modport master (
    output sad_start, sad_valid, sad_in,
    input  busy, result_valid, best_sad, best_mv_x, best_mv_y
  );

  modport slave (
    input  sad_start, sad_valid, sad_in,
    output busy, result_valid, best_sad, best_mv_x, best_mv_y
  );
endinterface

// File: rtl/sad_min_select.sv
// rtl/sad_min_select.sv - minimum-SAD tracker over a raster-ordered search window
module sad_min_select #(
  parameter int SAD_WIDTH = 16,
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int MV_WIDTH  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  sad_min_select_if.slave bus
);

  localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [CW-1:0]       COL_LAST = CW'(GRID_W - 1);
  localparam logic [RW-1:0]       ROW_LAST = RW'(GRID_H - 1);
  localparam logic [MV_WIDTH-1:0] HALF_W   = MV_WIDTH'(GRID_W / 2);
  localparam logic [MV_WIDTH-1:0] HALF_H   = MV_WIDTH'(GRID_H / 2);

  logic [1:0]           state_q,     state_d;
  logic [SAD_WIDTH-1:0] min_q,       min_d;
  logic [CW-1:0]        min_col_q,   min_col_d;
  logic [RW-1:0]        min_row_q,   min_row_d;
  logic [CW-1:0]        col_q,       col_d;
  logic [RW-1:0]        row_q,       row_d;
  logic [SAD_WIDTH-1:0] best_sad_q,  best_sad_d;
  logic [MV_WIDTH-1:0]  best_mv_x_q, best_mv_x_d;
  logic [MV_WIDTH-1:0]  best_mv_y_q, best_mv_y_d;

  // A start in the same cycle as a valid makes that candidate (0,0) of the new
  // block, so the search context is taken from the cleared values, not the regs.
  logic [CW-1:0]        cur_col, cur_min_col, new_col;
  logic [RW-1:0]        cur_row, cur_min_row, new_row;
  logic [SAD_WIDTH-1:0] cur_min, new_min;
  logic                 accept, first, take, col_last, last;

  always_comb begin
    cur_col     = bus.sad_start ? '0 : col_q;
    cur_row     = bus.sad_start ? '0 : row_q;
    cur_min     = bus.sad_start ? '1 : min_q;
    cur_min_col = bus.sad_start ? '0 : min_col_q;
    cur_min_row = bus.sad_start ? '0 : min_row_q;

    accept   = bus.sad_valid && (bus.sad_start || (state_q == ST_SEARCH));
    first    = (cur_col == '0) && (cur_row == '0);
    // Strict compare keeps the earliest candidate on ties; the first candidate
    // always loads so an all-ones SAD still yields position (0,0).
    take     = accept && (first || (bus.sad_in < cur_min));
    col_last = (cur_col == COL_LAST);
    last     = accept && col_last && (cur_row == ROW_LAST);

    new_min  = take ? bus.sad_in : cur_min;
    new_col  = take ? cur_col    : cur_min_col;
    new_row  = take ? cur_row    : cur_min_row;
  end

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    min_col_d   = min_col_q;
    min_row_d   = min_row_q;
    col_d       = col_q;
    row_d       = row_q;
    best_sad_d  = best_sad_q;
    best_mv_x_d = best_mv_x_q;
    best_mv_y_d = best_mv_y_q;

    case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_SEARCH: state_d = ST_SEARCH;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (bus.sad_start) begin
      state_d   = ST_SEARCH;
      min_d     = '1;
      min_col_d = '0;
      min_row_d = '0;
      col_d     = '0;
      row_d     = '0;
    end

    if (accept) begin
      min_d     = new_min;
      min_col_d = new_col;
      min_row_d = new_row;
      if (last) begin
        state_d     = ST_DONE;
        col_d       = '0;
        row_d       = '0;
        best_sad_d  = new_min;
        best_mv_x_d = MV_WIDTH'(new_col) - HALF_W;
        best_mv_y_d = MV_WIDTH'(new_row) - HALF_H;
      end else if (col_last) begin
        col_d = '0;
        row_d = cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      min_q       <= '1;
      min_col_q   <= '0;
      min_row_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      best_sad_q  <= '0;
      best_mv_x_q <= '0;
      best_mv_y_q <= '0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      min_col_q   <= min_col_d;
      min_row_q   <= min_row_d;
      col_q       <= col_d;
      row_q       <= row_d;
      best_sad_q  <= best_sad_d;
      best_mv_x_q <= best_mv_x_d;
      best_mv_y_q <= best_mv_y_d;
    end
  end

  assign bus.busy         = (state_q == ST_SEARCH);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.best_sad     = best_sad_q;
  assign bus.best_mv_x    = best_mv_x_q;
  assign bus.best_mv_y    = best_mv_y_q;

endmodule
